of_lookup_keygen: RTL and testbench
===================================

// Module: of_lookup_keygen
// PURPOSE
//  Per-port header parser that sits directly upstream of the flow-lookup stage.
//  Watches one port's received byte stream (preamble/SFD already stripped, byte 0 = dst MAC[47:40]).
//  Builds the 116-bit lookup key, then runs the of_lookup req/ack handshake.
//  Forwards the lookup result (fwd port mask, error) to the forwarding stage and keeps drop/timeout statistics.
// PARAMETERS
//  NPORT     4'h4     number of switch ports (width reference only)
//  PORT_NUM  4'h0     ingress port id, placed in key[115:112]
//  TIMEOUT   8'd32    max cycles to wait for of_lookup_ack before abandoning the lookup
// PORTS
//  sys_clk             in   1    single clock for all logic
//  sys_rst_n           in   1    asynchronous, active-low reset
//  rx_dv               in   1    frame byte valid; high for the whole frame, low between frames
//  rx_data             in   8    frame byte
//  of_lookup_req       out  1    lookup request, held until ack or timeout
//  of_lookup_data      out  116  key {PORT_NUM[3:0], srcmac[47:0], srcip[31:0], dstip[31:0]}
//  of_lookup_ack       in   1    single-cycle lookup completion
//  of_lookup_err       in   1    lookup error, sampled with ack
//  of_lookup_fwd_port  in   4    forward port mask, sampled with ack
//  res_valid           out  1    1-cycle pulse: result for the current frame
//  res_fwd_port        out  4    registered fwd mask (valid with res_valid, held after)
//  res_err             out  1    lookup err OR timeout (valid with res_valid)
//  cnt_lookup          out  16   completed lookups (ack received), wraps at 0xFFFF->0
//  cnt_timeout         out  16   lookups abandoned on timeout, wraps
//  cnt_drop            out  16   frames never looked up (short, non-IPv4, busy), wraps
// BEHAVIOUR
//  Reset (sys_rst_n=0, async): every output = 0, state=IDLE, byte counter=0, key regs=0.
//  Byte counter bcnt (6b, saturates at 63) counts bytes while rx_dv=1; 0 on the first byte.
//  Captures: srcmac = bytes 6..11; ethertype = bytes 12..13; srcip = bytes 26..29; dstip = bytes 30..33; MSB first.
//  FSM states:
//   IDLE: rx_dv=1 -> HDR; the current byte is bcnt=0.
//   HDR: capture bytes.
//    - If rx_dv=0 before byte 33: cnt_drop++, go to IDLE.
//    - Byte 13 done and ethertype != 16'h0800: cnt_drop++, go to SKIP.
//    - Byte 33 captured: go to REQ and assert of_lookup_req on the next cycle.
//   REQ: of_lookup_req=1, of_lookup_data stable, timer counts from 0.
//    - If ack=1: latch fwd/err, res_valid=1 next cycle, res_err=of_lookup_err, cnt_lookup++, req drops the same edge.
//    - If timer reaches TIMEOUT-1 with no ack: req=0, res_valid=1, res_err=1, res_fwd_port=0, cnt_timeout++.
//    - Exit to SKIP if rx_dv=1, otherwise to IDLE.
//   SKIP: ignore bytes until rx_dv=0, then go to IDLE.
//  Rules:
//   - Latency: req rises 1 cycle after byte 33 is sampled. res_valid comes 1 cycle after ack.
//   - Ack arriving when not in REQ is ignored; no counter changes.
//   - A frame whose rx_dv rises while in REQ is not parsed; cnt_drop++ once at its start. After REQ the FSM goes to SKIP for it.
//   - rx_dv falling while in REQ does not cancel the lookup; the result is still produced.
//   - Ack and timeout in the same cycle: ack wins, treated as a normal completion.
//   - of_lookup_data changes only on a state transition HDR->REQ.
//   - Async reset mid-REQ: req drops immediately; no result pulse is emitted.
// TESTING
//  1. 64B IPv4 frame, src 40:6c:8f:37:f1:f8, srcip 10.0.0.200, dstip 10.0.0.2, PORT_NUM=0
//     -> req 1 cycle after byte 33, data=116'h0_406c8f37f1f8_0A0000C8_0A000002.
//  2. Case 1 with a stub acking after 1 cycle with fwd=4'hF, err=0
//     -> res_valid single pulse, res_fwd_port=4'hF, res_err=0, cnt_lookup=1.
//  3. ARP frame (ethertype 0x0806) -> no req, cnt_drop=1, FSM back to IDLE after rx_dv falls.
//  4. 20-byte runt frame -> no req, cnt_drop=1; the next valid frame is looked up normally.
//  5. Stub never acks, TIMEOUT=32 -> req high exactly 32 cycles, res_err=1, res_fwd_port=0, cnt_timeout=1.
//  6. sys_rst_n pulsed low while req=1 -> all outputs 0 at once; after release, a new frame is parsed correctly.

Source files
------------

// File: rtl/of_lookup_keygen_if.sv
// of_lookup_keygen_if: flow-lookup handshake between the key generator (master) and the lookup stage (slave).
interface of_lookup_keygen_if #(
    parameter int NPORT = 4
);
    logic             of_lookup_req;
    logic [115:0]     of_lookup_data;
    logic             of_lookup_ack;
    logic             of_lookup_err;
    logic [NPORT-1:0] of_lookup_fwd_port;

    modport master (
        output of_lookup_req, of_lookup_data,
        input  of_lookup_ack, of_lookup_err, of_lookup_fwd_port
    );

    modport slave (
        input  of_lookup_req, of_lookup_data,
        output of_lookup_ack, of_lookup_err, of_lookup_fwd_port
    );
endinterface

// File: rtl/of_lookup_keygen.sv
// of_lookup_keygen: per-port Ethernet/IPv4 header parser that builds the 116-bit flow-lookup key,
// runs the lookup req/ack handshake with a timeout, and keeps lookup/timeout/drop statistics.
module of_lookup_keygen #(
    parameter logic [3:0] NPORT    = 4'h4,
    parameter logic [3:0] PORT_NUM = 4'h0,
    parameter logic [7:0] TIMEOUT  = 8'd32
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               rx_dv,
    input  logic [7:0]         rx_data,
    of_lookup_keygen_if.master lk,
    output logic               res_valid,
    output logic [NPORT-1:0]   res_fwd_port,
    output logic               res_err,
    output logic [15:0]        cnt_lookup,
    output logic [15:0]        cnt_timeout,
    output logic [15:0]        cnt_drop
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_SKIP = 2'd3;

    logic [1:0]  r_state;
    logic [5:0]  r_bcnt;
    logic [7:0]  r_tmr;
    logic [7:0]  r_eth_hi;
    logic        r_dv_d;
    logic [47:0] r_srcmac;
    logic [31:0] r_srcip;
    logic [23:0] r_dstip;
    logic        w_done;
    logic        w_non_ip;

    // ack wins over a timeout expiring in the same cycle
    assign w_done   = lk.of_lookup_ack || r_tmr == TIMEOUT - 8'd1;
    assign w_non_ip = r_bcnt == 6'd13 && {r_eth_hi, rx_data} != 16'h0800;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state           <= S_IDLE;
            r_bcnt            <= 6'd0;
            r_tmr             <= 8'd0;
            r_eth_hi          <= 8'd0;
            r_dv_d            <= 1'b0;
            r_srcmac          <= 48'd0;
            r_srcip           <= 32'd0;
            r_dstip           <= 24'd0;
            lk.of_lookup_req  <= 1'b0;
            lk.of_lookup_data <= 116'd0;
            res_valid         <= 1'b0;
            res_fwd_port      <= '0;
            res_err           <= 1'b0;
            cnt_lookup        <= 16'd0;
            cnt_timeout       <= 16'd0;
            cnt_drop          <= 16'd0;
        end else begin
            r_dv_d    <= rx_dv;
            r_bcnt    <= rx_dv ? r_bcnt + {5'd0, r_bcnt != 6'd63} : 6'd0;
            res_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (rx_dv) r_state <= S_HDR;
                S_HDR: begin
                    // shift registers are fully refilled by every frame before byte 33
                    if (r_bcnt >= 6'd6 && r_bcnt <= 6'd11) r_srcmac <= {r_srcmac[39:0], rx_data};
                    if (r_bcnt == 6'd12) r_eth_hi <= rx_data;
                    if (r_bcnt >= 6'd26 && r_bcnt <= 6'd29) r_srcip <= {r_srcip[23:0], rx_data};
                    if (r_bcnt >= 6'd30 && r_bcnt <= 6'd32) r_dstip <= {r_dstip[15:0], rx_data};
                    if (!rx_dv || w_non_ip) begin
                        cnt_drop <= cnt_drop + 16'd1;
                        r_state  <= rx_dv ? S_SKIP : S_IDLE;
                    end else if (r_bcnt == 6'd33) begin
                        r_state           <= S_REQ;
                        r_tmr             <= 8'd0;
                        lk.of_lookup_req  <= 1'b1;
                        lk.of_lookup_data <= {PORT_NUM, r_srcmac, r_srcip, r_dstip, rx_data};
                    end
                end
                S_REQ: begin
                    if (rx_dv && !r_dv_d) cnt_drop <= cnt_drop + 16'd1;
                    if (w_done) begin
                        lk.of_lookup_req <= 1'b0;
                        res_valid        <= 1'b1;
                        res_fwd_port     <= lk.of_lookup_ack ? lk.of_lookup_fwd_port : '0;
                        res_err          <= lk.of_lookup_ack ? lk.of_lookup_err : 1'b1;
                        cnt_lookup       <= cnt_lookup + {15'd0, lk.of_lookup_ack};
                        cnt_timeout      <= cnt_timeout + {15'd0, !lk.of_lookup_ack};
                        r_state          <= rx_dv ? S_SKIP : S_IDLE;
                    end else begin
                        r_tmr <= r_tmr + 8'd1;
                    end
                end
                default: if (!rx_dv) r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_of_lookup_keygen.sv
// tb_of_lookup_keygen: randomized frame stimulus with an ack stub, checked against a field-level model
// of the expected key, result timing and statistics counters.
module tb_of_lookup_keygen;
    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         rx_dv = 1'b0;
    logic [7:0]   rx_data = 8'd0;
    logic         res_valid;
    logic [3:0]   res_fwd_port;
    logic         res_err;
    logic [15:0]  cnt_lookup;
    logic [15:0]  cnt_timeout;
    logic [15:0]  cnt_drop;

    of_lookup_keygen_if lk ();

    of_lookup_keygen dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx_dv        (rx_dv),
        .rx_data      (rx_data),
        .lk           (lk),
        .res_valid    (res_valid),
        .res_fwd_port (res_fwd_port),
        .res_err      (res_err),
        .cnt_lookup   (cnt_lookup),
        .cnt_timeout  (cnt_timeout),
        .cnt_drop     (cnt_drop)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0]   fr [0:63];
    int b33_cyc = 0;
    logic [15:0]  exp_lookup = 0, exp_timeout = 0, exp_drop = 0;

    // ack stub: acks ack_delay cycles after req is first seen (never if negative)
    int ack_delay = -1;
    int req_age = 0;
    int stub_ack_cyc = 0;
    logic force_ack = 1'b0;
    logic ack_hit;

    int mon_req_rise, mon_req_n, mon_res_n, mon_res_cyc;
    logic mon_prev_req, mon_res_err, mon_key_moved;
    logic [3:0] mon_res_fwd;
    logic [115:0] mon_key;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        ack_hit = lk.of_lookup_req && ack_delay >= 0 && req_age == ack_delay;
        lk.of_lookup_ack = ack_hit || force_ack;
        if (ack_hit) stub_ack_cyc = cyc;
        req_age = lk.of_lookup_req ? req_age + 1 : 0;
    end

    always @(negedge sys_clk) begin
        if (lk.of_lookup_req) begin
            if (!mon_prev_req) begin
                mon_req_rise = cyc;
                mon_key = lk.of_lookup_data;
            end else if (lk.of_lookup_data !== mon_key) mon_key_moved = 1'b1;
            mon_req_n++;
        end
        mon_prev_req = lk.of_lookup_req;
        if (res_valid) begin
            mon_res_n++;
            mon_res_cyc = cyc;
            mon_res_fwd = res_fwd_port;
            mon_res_err = res_err;
        end
    end

    task automatic clear_mon();
        mon_req_rise = -1; mon_req_n = 0; mon_res_n = 0; mon_res_cyc = -1;
        mon_prev_req = 1'b0; mon_res_err = 1'b0; mon_res_fwd = 4'd0; mon_key = '0; mon_key_moved = 1'b0;
    endtask

    task automatic build_frame(input logic [47:0] smac, input logic [15:0] et, input logic [31:0] sip, input logic [31:0] dip);
        for (int i = 0; i < 64; i++) fr[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) fr[6 + i] = smac[47 - 8*i -: 8];
        fr[12] = et[15:8];
        fr[13] = et[7:0];
        for (int i = 0; i < 4; i++) begin
            fr[26 + i] = sip[31 - 8*i -: 8];
            fr[30 + i] = dip[31 - 8*i -: 8];
        end
    endtask

    task automatic send_frame(input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge sys_clk);
            rx_dv = 1'b1;
            rx_data = fr[i];
            if (i == 33) b33_cyc = cyc + 1;
        end
        @(negedge sys_clk);
        rx_dv = 1'b0;
        rx_data = 8'd0;
    endtask

    task automatic settle();
        repeat (45) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (lk.of_lookup_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0h exp=0", lk.of_lookup_req); end
        checks++; if (lk.of_lookup_data !== 116'd0) begin errors++; $display("FAIL reset_data got=%0h exp=0", lk.of_lookup_data); end
        checks++; if ({res_valid, res_fwd_port, res_err} !== 6'd0) begin errors++; $display("FAIL reset_res got=%0h exp=0", {res_valid, res_fwd_port, res_err}); end
        checks++; if ({cnt_lookup, cnt_timeout, cnt_drop} !== 48'd0) begin errors++; $display("FAIL reset_cnt got=%0h exp=0", {cnt_lookup, cnt_timeout, cnt_drop}); end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_ipv4_ack();
        clear_mon();
        ack_delay = 1; lk.of_lookup_fwd_port = 4'hF; lk.of_lookup_err = 1'b0;
        build_frame(48'h406c8f37f1f8, 16'h0800, 32'h0A0000C8, 32'h0A000002);
        send_frame(64);
        settle();
        exp_lookup++;
        checks++; if (mon_req_rise !== b33_cyc) begin errors++; $display("FAIL ipv4_req_latency got=%0d exp=%0d", mon_req_rise, b33_cyc); end
        checks++; if (mon_key !== 116'h0_406c8f37f1f8_0A0000C8_0A000002) begin errors++; $display("FAIL ipv4_key got=%0h exp=0406c8f37f1f80a0000c80a000002", mon_key); end
        checks++; if (mon_req_n !== 2) begin errors++; $display("FAIL ipv4_req_cycles got=%0d exp=2", mon_req_n); end
        checks++; if (mon_res_n !== 1) begin errors++; $display("FAIL ipv4_res_pulses got=%0d exp=1", mon_res_n); end
        checks++; if (mon_res_cyc !== stub_ack_cyc + 1) begin errors++; $display("FAIL ipv4_res_latency got=%0d exp=%0d", mon_res_cyc, stub_ack_cyc + 1); end
        checks++; if ({mon_res_fwd, mon_res_err} !== {4'hF, 1'b0}) begin errors++; $display("FAIL ipv4_res got=%0h exp=1e", {mon_res_fwd, mon_res_err}); end
        checks++; if (cnt_lookup !== exp_lookup) begin errors++; $display("FAIL ipv4_cnt_lookup got=%0d exp=%0d", cnt_lookup, exp_lookup); end
        checks++; if (res_fwd_port !== 4'hF) begin errors++; $display("FAIL ipv4_fwd_held got=%0h exp=f", res_fwd_port); end
    endtask

    task automatic test_arp();
        clear_mon();
        build_frame(48'h0200_0000_0001, 16'h0806, 32'h0A000001, 32'h0A000002);
        send_frame(64);
        settle();
        exp_drop++;
        checks++; if (mon_req_n !== 0 || mon_res_n !== 0) begin errors++; $display("FAIL arp_no_req got=%0d/%0d exp=0/0", mon_req_n, mon_res_n); end
        checks++; if (cnt_drop !== exp_drop) begin errors++; $display("FAIL arp_cnt_drop got=%0d exp=%0d", cnt_drop, exp_drop); end
    endtask

    task automatic test_runt();
        logic [47:0] sm;
        logic [31:0] si, di;
        clear_mon();
        build_frame(48'h0200_0000_0002, 16'h0800, 32'h0A000003, 32'h0A000004);
        send_frame(20);
        settle();
        exp_drop++;
        checks++; if (mon_req_n !== 0) begin errors++; $display("FAIL runt_no_req got=%0d exp=0", mon_req_n); end
        checks++; if (cnt_drop !== exp_drop) begin errors++; $display("FAIL runt_cnt_drop got=%0d exp=%0d", cnt_drop, exp_drop); end
        clear_mon();
        sm = {16'($urandom), $urandom}; si = $urandom; di = $urandom;
        ack_delay = 0; lk.of_lookup_fwd_port = 4'h3; lk.of_lookup_err = 1'b1;
        build_frame(sm, 16'h0800, si, di);
        send_frame(60);
        settle();
        exp_lookup++;
        checks++; if (mon_key !== {4'h0, sm, si, di}) begin errors++; $display("FAIL runt_next_key got=%0h exp=%0h", mon_key, {4'h0, sm, si, di}); end
        checks++; if ({mon_res_n, mon_res_fwd, mon_res_err} !== {32'd1, 4'h3, 1'b1}) begin errors++; $display("FAIL runt_next_res got=%0h exp=%0h", {mon_res_fwd, mon_res_err}, 5'h07); end
        checks++; if (cnt_lookup !== exp_lookup) begin errors++; $display("FAIL runt_next_cnt got=%0d exp=%0d", cnt_lookup, exp_lookup); end
    endtask

    task automatic test_timeout();
        clear_mon();
        ack_delay = -1; lk.of_lookup_fwd_port = 4'hA; lk.of_lookup_err = 1'b0;
        build_frame(48'h0200_0000_0003, 16'h0800, 32'hC0A80001, 32'hC0A80002);
        send_frame(64);
        settle();
        exp_timeout++;
        checks++; if (mon_req_n !== 32) begin errors++; $display("FAIL timeout_req_cycles got=%0d exp=32", mon_req_n); end
        checks++; if (mon_res_n !== 1 || mon_res_cyc !== mon_req_rise + 32) begin errors++; $display("FAIL timeout_res_timing got=%0d@%0d exp=1@%0d", mon_res_n, mon_res_cyc, mon_req_rise + 32); end
        checks++; if ({mon_res_fwd, mon_res_err} !== 5'h01) begin errors++; $display("FAIL timeout_res got=%0h exp=01", {mon_res_fwd, mon_res_err}); end
        checks++; if ({cnt_timeout, cnt_lookup} !== {exp_timeout, exp_lookup}) begin errors++; $display("FAIL timeout_cnt got=%0h exp=%0h", {cnt_timeout, cnt_lookup}, {exp_timeout, exp_lookup}); end
        clear_mon();
        ack_delay = 31; lk.of_lookup_fwd_port = 4'h5;
        build_frame(48'h0200_0000_0004, 16'h0800, 32'hC0A80003, 32'hC0A80004);
        send_frame(64);
        settle();
        exp_lookup++;
        checks++; if (mon_req_n !== 32 || {mon_res_fwd, mon_res_err} !== 5'h0A) begin errors++; $display("FAIL ack_at_timeout got=%0d/%0h exp=32/0a", mon_req_n, {mon_res_fwd, mon_res_err}); end
        checks++; if ({cnt_timeout, cnt_lookup} !== {exp_timeout, exp_lookup}) begin errors++; $display("FAIL ack_at_timeout_cnt got=%0h exp=%0h", {cnt_timeout, cnt_lookup}, {exp_timeout, exp_lookup}); end
    endtask

    task automatic test_busy_drop();
        logic [115:0] key_a;
        clear_mon();
        ack_delay = 20; lk.of_lookup_fwd_port = 4'h6; lk.of_lookup_err = 1'b0;
        build_frame(48'h0200_0000_0005, 16'h0800, 32'h01020304, 32'h05060708);
        key_a = {4'h0, 48'h0200_0000_0005, 32'h01020304, 32'h05060708};
        send_frame(34);
        build_frame(48'h0200_0000_0006, 16'h0800, 32'h11121314, 32'h15161718);
        send_frame(64);
        settle();
        exp_lookup++; exp_drop++;
        checks++; if (mon_req_n !== 21 || mon_key !== key_a || mon_key_moved) begin errors++; $display("FAIL busy_req got=%0d/%0h exp=21/%0h", mon_req_n, mon_key, key_a); end
        checks++; if (mon_res_n !== 1 || mon_res_fwd !== 4'h6) begin errors++; $display("FAIL busy_res got=%0d/%0h exp=1/6", mon_res_n, mon_res_fwd); end
        checks++; if ({cnt_lookup, cnt_drop} !== {exp_lookup, exp_drop}) begin errors++; $display("FAIL busy_cnt got=%0h exp=%0h", {cnt_lookup, cnt_drop}, {exp_lookup, exp_drop}); end
    endtask

    task automatic test_ack_outside_req();
        clear_mon();
        @(negedge sys_clk); force_ack = 1'b1;
        repeat (5) @(negedge sys_clk);
        force_ack = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (mon_res_n !== 0) begin errors++; $display("FAIL stray_ack_res got=%0d exp=0", mon_res_n); end
        checks++; if ({cnt_lookup, cnt_timeout, cnt_drop} !== {exp_lookup, exp_timeout, exp_drop}) begin errors++; $display("FAIL stray_ack_cnt got=%0h exp=%0h", {cnt_lookup, cnt_timeout, cnt_drop}, {exp_lookup, exp_timeout, exp_drop}); end
    endtask

    task automatic test_random();
        logic [47:0] sm;
        logic [31:0] si, di;
        logic [15:0] et;
        logic [3:0]  fwd;
        logic        err, good;
        int len, d, sel;
        for (int n = 0; n < 14; n++) begin
            clear_mon();
            sm = {16'($urandom), $urandom}; si = $urandom; di = $urandom;
            sel = $urandom_range(0, 4);
            len = sel == 0 ? 20 : sel == 1 ? 33 : $urandom_range(34, 64);
            et = $urandom_range(0, 3) == 0 ? 16'h86DD : 16'h0800;
            d = $urandom_range(0, 40);
            fwd = 4'($urandom); err = 1'($urandom);
            ack_delay = d; lk.of_lookup_fwd_port = fwd; lk.of_lookup_err = err;
            good = len >= 34 && et == 16'h0800;
            build_frame(sm, et, si, di);
            send_frame(len);
            settle();
            if (!good) exp_drop++;
            else if (d <= 31) exp_lookup++;
            else exp_timeout++;
            if (good) begin
                checks++; if (mon_req_rise !== b33_cyc || mon_key !== {4'h0, sm, si, di} || mon_key_moved) begin errors++; $display("FAIL rnd%0d_req got=%0d/%0h exp=%0d/%0h", n, mon_req_rise, mon_key, b33_cyc, {4'h0, sm, si, di}); end
                if (d <= 31) begin
                    checks++; if (mon_req_n !== d + 1 || mon_res_n !== 1 || mon_res_cyc !== stub_ack_cyc + 1 || {mon_res_fwd, mon_res_err} !== {fwd, err}) begin errors++; $display("FAIL rnd%0d_ack got=%0d/%0d/%0h exp=%0d/1/%0h", n, mon_req_n, mon_res_n, {mon_res_fwd, mon_res_err}, d + 1, {fwd, err}); end
                end else begin
                    checks++; if (mon_req_n !== 32 || mon_res_n !== 1 || {mon_res_fwd, mon_res_err} !== 5'h01) begin errors++; $display("FAIL rnd%0d_timeout got=%0d/%0d/%0h exp=32/1/01", n, mon_req_n, mon_res_n, {mon_res_fwd, mon_res_err}); end
                end
            end else begin
                checks++; if (mon_req_n !== 0 || mon_res_n !== 0) begin errors++; $display("FAIL rnd%0d_drop got=%0d/%0d exp=0/0", n, mon_req_n, mon_res_n); end
            end
            checks++; if ({cnt_lookup, cnt_timeout, cnt_drop} !== {exp_lookup, exp_timeout, exp_drop}) begin errors++; $display("FAIL rnd%0d_cnt got=%0h exp=%0h", n, {cnt_lookup, cnt_timeout, cnt_drop}, {exp_lookup, exp_timeout, exp_drop}); end
        end
    endtask

    task automatic test_reset_mid_req();
        logic [47:0] sm;
        logic [31:0] si, di;
        clear_mon();
        ack_delay = -1;
        build_frame(48'h0200_0000_0007, 16'h0800, 32'h0A0A0A0A, 32'h0B0B0B0B);
        send_frame(40);
        repeat (2) @(negedge sys_clk);
        checks++; if (lk.of_lookup_req !== 1'b1) begin errors++; $display("FAIL rstreq_pre_req got=%0h exp=1", lk.of_lookup_req); end
        sys_rst_n = 1'b0;
        #1;
        exp_lookup = 0; exp_timeout = 0; exp_drop = 0;
        checks++; if ({lk.of_lookup_req, res_valid, res_err, res_fwd_port} !== 7'd0 || lk.of_lookup_data !== 116'd0) begin errors++; $display("FAIL rstreq_outputs got=%0h exp=0", {lk.of_lookup_req, res_valid, res_err, res_fwd_port}); end
        checks++; if ({cnt_lookup, cnt_timeout, cnt_drop} !== 48'd0) begin errors++; $display("FAIL rstreq_cnt got=%0h exp=0", {cnt_lookup, cnt_timeout, cnt_drop}); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_mon();
        repeat (40) @(negedge sys_clk);
        checks++; if (mon_res_n !== 0 || mon_req_n !== 0) begin errors++; $display("FAIL rstreq_no_result got=%0d/%0d exp=0/0", mon_res_n, mon_req_n); end
        clear_mon();
        sm = {16'($urandom), $urandom}; si = $urandom; di = $urandom;
        ack_delay = 2; lk.of_lookup_fwd_port = 4'h9; lk.of_lookup_err = 1'b0;
        build_frame(sm, 16'h0800, si, di);
        send_frame(64);
        settle();
        exp_lookup++;
        checks++; if (mon_key !== {4'h0, sm, si, di} || mon_res_fwd !== 4'h9) begin errors++; $display("FAIL rstreq_next got=%0h/%0h exp=%0h/9", mon_key, mon_res_fwd, {4'h0, sm, si, di}); end
        checks++; if ({cnt_lookup, cnt_timeout, cnt_drop} !== {exp_lookup, exp_timeout, exp_drop}) begin errors++; $display("FAIL rstreq_next_cnt got=%0h exp=%0h", {cnt_lookup, cnt_timeout, cnt_drop}, {exp_lookup, exp_timeout, exp_drop}); end
    endtask

    initial begin
        lk.of_lookup_err = 1'b0;
        lk.of_lookup_fwd_port = 4'd0;
        clear_mon();
        test_reset();
        test_ipv4_ack();
        test_arp();
        test_runt();
        test_timeout();
        test_busy_drop();
        test_ack_outside_req();
        test_random();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
